seq_gen: RTL and testbench
==========================

// Module: seq_gen
// PURPOSE
//  Serial pattern transmitter; the transmit-side counterpart of the sequence
//  detector. Accepts a command carrying a PAT_W-bit pattern, a repeat count
//  and an inter-frame gap, then drives the pattern MSB-first, one bit per clk,
//  on a single serial line. Sits upstream of the detector as a stimulus and
//  link source. Reports completion with a one-cycle done pulse.
// PARAMETERS
//  PAT_W     4    pattern width in bits (>=2)
//  CNT_W     8    width of the repeat-count and gap-length fields
//  IDLE_BIT  1'b0 line level driven when no pattern bit is on the line
// PORTS
//  clk         in   1      clock; all logic rising-edge
//  rst         in   1      reset, asynchronous, active-low
//  cmdValid    in   1      command offered
//  cmdReady    out  1      command accepted when cmdValid&&cmdReady
//  cmdPat      in   PAT_W  pattern; bit PAT_W-1 is sent first
//  cmdRep      in   CNT_W  number of frames to send; 0 = send nothing
//  cmdGap      in   CNT_W  IDLE_BIT cycles inserted between frames
//  seqOut      out  1      serial data
//  seqValid    out  1      high while seqOut carries a pattern bit
//  frameStart  out  1      high with the first bit of each frame
//  busy        out  1      high from the cycle after accept until done
//  done        out  1      one-cycle pulse when the command completes
// BEHAVIOUR
//  - Reset (rst==0, async): state=IDLE; seqOut=IDLE_BIT; seqValid,
//    frameStart, busy, done = 0; cmdReady=1 (decoded from IDLE).
//  - Reset mid-operation: transfer aborted at once, no done pulse, and
//    latched command discarded.
//  - All outputs except cmdReady are registered. cmdReady = (state==IDLE).
//  - FSM states: IDLE, SHIFT, GAP, DONE.
//    IDLE:  on accept, latch pat/rep/gap (later port changes have no effect).
//           rep==0 -> DONE; else -> SHIFT, bitIdx=PAT_W-1, repLeft=rep.
//    SHIFT: seqOut=pat[bitIdx]; seqValid=1; frameStart=(bitIdx==PAT_W-1).
//           bitIdx!=0 -> bitIdx-1, stay in SHIFT.
//           bitIdx==0 -> repLeft-1. repLeft==1 -> DONE;
//           gap==0 -> SHIFT with bitIdx=PAT_W-1 (back-to-back);
//           otherwise -> GAP with gapCnt=gap.
//    GAP:   seqOut=IDLE_BIT, seqValid=0; gapCnt-1; gapCnt==1 -> SHIFT, reload.
//    DONE:  done=1 for exactly one cycle; seqValid=0; -> IDLE.
//  - Latency: accept at edge t -> first bit visible in cycle t+1.
//    Frame bits occupy R*PAT_W + (R-1)*G cycles (R=rep, G=gap). The done
//    pulse comes in the next cycle, and cmdReady=1 in the cycle after done.
//  - rep==0: done in cycle t+1, seqValid never asserted.
//  - cmdValid during busy/DONE is ignored (cmdReady=0) and must be held
//    by the source.
//  - Counters: bitIdx is $clog2(PAT_W) bits; repLeft and gapCnt are CNT_W
//    bits, unsigned, decrement-only, and never wrap (exit precedes 0).
// STRUCTURE
//  - Package seq_gen_pkg holds the state encoding constants (IDLE=0, SHIFT=1,
//    GAP=2, DONE=3, 2 bits) and the IDLE_BIT default.
//  - One sub-module, seq_down_cnt (load/dec/isOne), CNT_W wide, is
//    instantiated twice: repLeft and gapCnt. bitIdx and the pattern register
//    stay inline.
// TESTING
//  1 rst low for 3 cycles with cmdValid=1 -> seqOut=0, seqValid=0, busy=0,
//    done=0, cmdReady=1; nothing accepted until after release.
//  2 pat=4'b1001, rep=1, gap=0, accept at t -> seqOut 1,0,0,1 in t+1..t+4,
//    seqValid=1 and frameStart=1 only in t+1, done in t+5, cmdReady in t+6.
//    Looped into the detector, detOut=1 in t+5.
//  3 pat=4'b1001, rep=3, gap=2 -> valid bits in t+1..4, t+7..10 and
//    t+13..16; seqOut=0, seqValid=0 in t+5,6 and t+11,12; done in t+17.
//  4 pat=4'b1011, rep=2, gap=0, cmdValid held high throughout -> 8
//    contiguous bits 1,0,1,1,1,0,1,1; frameStart at t+1 and t+5; done in
//    t+9. Second command accepted only in t+10.
//  5 rep=0 -> done in t+1, seqValid never asserted, cmdReady back in t+2.
//  6 rep=2 gap=1, rst low during the 3rd bit -> outputs reset in the same
//    cycle, no done. After release, a fresh command (test 2) runs exactly.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared constants for the serial pattern transmitter: FSM encoding,
// default geometry and the idle line level.
package seq_gen_pkg;

   localparam int unsigned PAT_W_DEF = 4;
   localparam int unsigned CNT_W_DEF = 8;

   localparam logic IDLE_BIT_DEF = 1'b0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage : seq_gen_pkg

// File: rtl/seq_gen_if.sv
// Command handshake and serial output bundle between a command source
// (master) and the transmitter (slave).
interface seq_gen_if
   import seq_gen_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
);

   logic             cmdValid;
   logic             cmdReady;
   logic [PAT_W-1:0] cmdPat;
   logic [CNT_W-1:0] cmdRep;
   logic [CNT_W-1:0] cmdGap;
   logic             seqOut;
   logic             seqValid;
   logic             frameStart;
   logic             busy;
   logic             done;

   modport master (
      output cmdValid, cmdPat, cmdRep, cmdGap,
      input  cmdReady, seqOut, seqValid, frameStart, busy, done
   );

   modport slave (
      input  cmdValid, cmdPat, cmdRep, cmdGap,
      output cmdReady, seqOut, seqValid, frameStart, busy, done
   );

endinterface : seq_gen_if

// File: rtl/seq_down_cnt.sv
// Loadable decrement-only counter with a registered value and a decoded
// "equals one" flag used as the loop-exit condition.
module seq_down_cnt
   import seq_gen_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             is_one_c_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load wins over decrement; saturate at zero rather than wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign is_one_c_o = (cnt_q == CNT_W'(1));

endmodule : seq_down_cnt

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, a given
// number of times with idle gaps between frames, then pulses done.
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned PAT_W    = PAT_W_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter logic        IDLE_BIT = IDLE_BIT_DEF
) (
   input  logic      clk,
   input  logic      rst,
   seq_gen_if.slave  bus
);

   localparam int unsigned        BIT_W   = $clog2(PAT_W);
   localparam logic [BIT_W-1:0]   BIT_MAX = BIT_W'(PAT_W - 1);

   logic [1:0]       state_q, state_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] gap_q, gap_d;

   logic seq_out_q, seq_out_d;
   logic seq_valid_q, seq_valid_d;
   logic frame_start_q, frame_start_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic accept_c;
   logic rep_load_c, rep_dec_c, rep_one_c;
   logic gap_load_c, gap_dec_c, gap_one_c;

   assign accept_c = bus.cmdValid && (state_q == ST_IDLE);

   seq_down_cnt #(.CNT_W(CNT_W)) u_rep_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (rep_load_c),
      .dec_i      (rep_dec_c),
      .load_val_i (bus.cmdRep),
      .is_one_c_o (rep_one_c)
   );

   seq_down_cnt #(.CNT_W(CNT_W)) u_gap_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (gap_load_c),
      .dec_i      (gap_dec_c),
      .load_val_i (gap_q),
      .is_one_c_o (gap_one_c)
   );

   // Next state, then outputs decoded from the next state so the
   // registered outputs line up with the state they describe.
   always_comb begin
      state_d       = state_q;
      bit_d         = bit_q;
      pat_d         = pat_q;
      gap_d         = gap_q;
      rep_load_c    = 1'b0;
      rep_dec_c     = 1'b0;
      gap_load_c    = 1'b0;
      gap_dec_c     = 1'b0;
      seq_out_d     = IDLE_BIT;
      seq_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               pat_d = bus.cmdPat;
               gap_d = bus.cmdGap;
               if (bus.cmdRep == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_SHIFT;
                  bit_d      = BIT_MAX;
                  rep_load_c = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            if (bit_q != '0) begin
               bit_d = bit_q - BIT_W'(1);
            end else begin
               rep_dec_c = 1'b1;
               if (rep_one_c) begin
                  state_d = ST_DONE;
               end else if (gap_q == '0) begin
                  bit_d = BIT_MAX;
               end else begin
                  state_d    = ST_GAP;
                  gap_load_c = 1'b1;
               end
            end
         end
         ST_GAP: begin
            gap_dec_c = 1'b1;
            if (gap_one_c) begin
               state_d = ST_SHIFT;
               bit_d   = BIT_MAX;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
      if (state_d == ST_SHIFT) begin
         seq_out_d     = pat_d[bit_d];
         seq_valid_d   = 1'b1;
         frame_start_d = (bit_d == BIT_MAX);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         bit_q         <= '0;
         pat_q         <= '0;
         gap_q         <= '0;
         seq_out_q     <= IDLE_BIT;
         seq_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_q         <= bit_d;
         pat_q         <= pat_d;
         gap_q         <= gap_d;
         seq_out_q     <= seq_out_d;
         seq_valid_q   <= seq_valid_d;
         frame_start_q <= frame_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bus.cmdReady   = (state_q == ST_IDLE);
   assign bus.seqOut     = seq_out_q;
   assign bus.seqValid   = seq_valid_q;
   assign bus.frameStart = frame_start_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule : seq_gen

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: per-cycle output vectors after each accepted
// command are compared against hand-written bit strings.
module tb_seq_gen;

   logic clk;
   logic rst;

   int n_checks = 0;
   int n_fail   = 0;

   seq_gen_if #(.PAT_W(4), .CNT_W(8)) bus ();

   seq_gen #(.PAT_W(4), .CNT_W(8), .IDLE_BIT(1'b0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
      end
   endtask

   // Output vector order: {busy, cmdReady, done, frameStart, seqValid, seqOut}
   function automatic logic [5:0] obs();
      return {bus.busy, bus.cmdReady, bus.done, bus.frameStart, bus.seqValid, bus.seqOut};
   endfunction

   // Issue a command at a negedge; it is accepted on the following posedge.
   task automatic issue(input logic [3:0] pat, input logic [7:0] rep,
                        input logic [7:0] gap, input bit hold);
      bus.cmdPat   = pat;
      bus.cmdRep   = rep;
      bus.cmdGap   = gap;
      bus.cmdValid = 1'b1;
      chk("ready_before_accept", 32'(bus.cmdReady), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) begin
         bus.cmdValid = 1'b0;
         bus.cmdPat   = ~pat;
         bus.cmdRep   = 8'd5;
         bus.cmdGap   = 8'd7;
      end
   endtask

   // Cycle t+k is checked against bit [n-k] of each expected string.
   task automatic run_trace(input string tag, input int n,
                            input logic [63:0] e_busy, input logic [63:0] e_rdy,
                            input logic [63:0] e_done, input logic [63:0] e_fs,
                            input logic [63:0] e_val, input logic [63:0] e_out);
      logic [5:0] exp;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         exp = {e_busy[n-k], e_rdy[n-k], e_done[n-k], e_fs[n-k], e_val[n-k], e_out[n-k]};
         chk($sformatf("%s_t+%0d", tag, k), 32'(obs()), 32'(exp));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b0;
      bus.cmdValid = 1'b1;
      bus.cmdPat   = 4'b1111;
      bus.cmdRep   = 8'd1;
      bus.cmdGap   = 8'd0;

      // Reset held with a command offered: idle outputs, ready high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("reset_c%0d", i), 32'(obs()), 32'b010000);
      end
      rst          = 1'b1;
      bus.cmdValid = 1'b0;
      @(negedge clk);
      chk("idle_after_release", 32'(obs()), 32'b010000);

      // Single frame, no gap
      issue(4'b1001, 8'd1, 8'd0, 1'b0);
      run_trace("t2", 6, 64'b111110, 64'b000001, 64'b000010,
                64'b100000, 64'b111100, 64'b100100);

      // Three frames with two-cycle gaps
      issue(4'b1001, 8'd3, 8'd2, 1'b0);
      run_trace("t3", 18,
                64'b111111_111111_111110, 64'b000000_000000_000001,
                64'b000000_000000_000010, 64'b100000_100000_100000,
                64'b111100_111100_111100, 64'b100100_100100_100100);

      // Back-to-back frames with cmdValid held; re-accept only once idle
      issue(4'b1011, 8'd2, 8'd0, 1'b1);
      run_trace("t4", 10, 64'b1111111110, 64'b0000000001, 64'b0000000010,
                64'b1000100000, 64'b1111111100, 64'b1011101100);
      @(posedge clk);
      #1;
      bus.cmdValid = 1'b0;
      @(negedge clk);
      chk("t4_second_accept", 32'(obs()), 32'b100111);
      repeat (9) @(negedge clk);
      chk("t4_second_idle", 32'(obs()), 32'b010000);

      // Zero repeat count: immediate done, no valid bits
      issue(4'b1111, 8'd0, 8'd3, 1'b0);
      run_trace("t5", 2, 64'b10, 64'b01, 64'b10, 64'b00, 64'b00, 64'b00);

      // Reset during the third bit aborts without done
      issue(4'b1001, 8'd2, 8'd1, 1'b0);
      run_trace("t6", 2, 64'b11, 64'b00, 64'b00, 64'b10, 64'b11, 64'b10);
      @(negedge clk);
      chk("t6_third_bit", 32'(obs()), 32'b100010);
      #1;
      rst = 1'b0;
      #1;
      chk("t6_async_reset", 32'(obs()), 32'b010000);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t6_no_done_c%0d", i), 32'(obs()), 32'b010000);
      end

      // Fresh command after the abort runs exactly
      issue(4'b1001, 8'd1, 8'd0, 1'b0);
      run_trace("t6_rerun", 6, 64'b111110, 64'b000001, 64'b000010,
                64'b100000, 64'b111100, 64'b100100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_seq_gen
